// File: rtl/forwarding_unit_pkg.sv
// Shared definitions for the forwarding unit: select width and encodings,
// default register-address width, and the select-priority helper.
package forwarding_unit_pkg;

    localparam int unsigned FORW_SEL_LEN         = 2;
    localparam int unsigned REG_ADDR_LEN_DEFAULT = 5;

    typedef enum logic [FORW_SEL_LEN-1:0] {
        FORW_SEL_REG = 2'd0,
        FORW_SEL_MEM = 2'd1,
        FORW_SEL_WB  = 2'd2
    } forw_sel_e;

    // The producer sitting in EXE at issue time is in MEM during the
    // consumer's EXE cycle, so it wins over the older MEM-slot producer.
    function automatic forw_sel_e pick_sel(input logic hit_exe, input logic hit_mem);
        if (hit_exe) return FORW_SEL_MEM;
        if (hit_mem) return FORW_SEL_WB;
        return FORW_SEL_REG;
    endfunction

endpackage

// File: rtl/forwarding_unit_dest_slot.sv
// One pipeline-stage shadow register holding {valid, wb_en, mem_read, dest}.
// A bubble load clears the slot instead of capturing the inputs.
module dest_slot
    import forwarding_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = REG_ADDR_LEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bubble,
    input  logic                    in_valid,
    input  logic                    in_wb_en,
    input  logic                    in_mem_read,
    input  logic [REG_ADDR_LEN-1:0] in_dest,
    output logic                    out_valid,
    output logic                    out_wb_en,
    output logic                    out_mem_read,
    output logic [REG_ADDR_LEN-1:0] out_dest
);

    logic                    valid_d, valid_q;
    logic                    wb_en_d, wb_en_q;
    logic                    mem_read_d, mem_read_q;
    logic [REG_ADDR_LEN-1:0] dest_d, dest_q;

    // Next slot contents: all-zero bubble or the incoming stage fields.
    always_comb begin
        valid_d    = 1'b0;
        wb_en_d    = 1'b0;
        mem_read_d = 1'b0;
        dest_d     = '0;
        if (!bubble) begin
            valid_d    = in_valid;
            wb_en_d    = in_wb_en;
            mem_read_d = in_mem_read;
            dest_d     = in_dest;
        end
    end

    // Slot register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_read_q <= 1'b0;
            dest_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            wb_en_q    <= wb_en_d;
            mem_read_q <= mem_read_d;
            dest_q     <= dest_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_wb_en    = wb_en_q;
    assign out_mem_read = mem_read_q;
    assign out_dest     = dest_q;

endmodule

// File: rtl/forwarding_unit.sv
// EXE-stage forwarding select generation and load-use stall detection.
// Tracks EXE/MEM/WB destinations in three dest_slot shadow registers.
// Build option FORWARDING_EN: when undefined, selects are constant 0 and
// any in-flight producer of a used source stalls ID.
module forwarding_unit
    import forwarding_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN  = REG_ADDR_LEN_DEFAULT,
    parameter int unsigned STALL_CNT_LEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_ADDR_LEN-1:0]  id_src1,
    input  logic [REG_ADDR_LEN-1:0]  id_src2,
    input  logic                     id_is_imm,
    input  logic                     id_is_store,
    input  logic                     id_wb_en,
    input  logic                     id_mem_read,
    input  logic [REG_ADDR_LEN-1:0]  id_dest,
    input  logic                     flush,
    output logic [FORW_SEL_LEN-1:0]  val1_sel,
    output logic [FORW_SEL_LEN-1:0]  val2_sel,
    output logic [FORW_SEL_LEN-1:0]  ST_val_sel,
    output logic                     hazard_stall,
    output logic [STALL_CNT_LEN-1:0] stall_count
);

    logic                    exe_valid, exe_wb_en, exe_mem_read;
    logic [REG_ADDR_LEN-1:0] exe_dest;
    logic                    mem_valid, mem_wb_en, mem_mem_read;
    logic [REG_ADDR_LEN-1:0] mem_dest;
    logic                    wb_valid, wb_wb_en, wb_mem_read;
    logic [REG_ADDR_LEN-1:0] wb_dest;
    logic                    exe_bubble;

    dest_slot #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_exe_slot (
        .clk          (clk),
        .rst          (rst),
        .bubble       (exe_bubble),
        .in_valid     (id_valid),
        .in_wb_en     (id_wb_en),
        .in_mem_read  (id_mem_read),
        .in_dest      (id_dest),
        .out_valid    (exe_valid),
        .out_wb_en    (exe_wb_en),
        .out_mem_read (exe_mem_read),
        .out_dest     (exe_dest)
    );

    dest_slot #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_mem_slot (
        .clk          (clk),
        .rst          (rst),
        .bubble       (1'b0),
        .in_valid     (exe_valid),
        .in_wb_en     (exe_wb_en),
        .in_mem_read  (exe_mem_read),
        .in_dest      (exe_dest),
        .out_valid    (mem_valid),
        .out_wb_en    (mem_wb_en),
        .out_mem_read (mem_mem_read),
        .out_dest     (mem_dest)
    );

    dest_slot #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_wb_slot (
        .clk          (clk),
        .rst          (rst),
        .bubble       (1'b0),
        .in_valid     (mem_valid),
        .in_wb_en     (mem_wb_en),
        .in_mem_read  (mem_mem_read),
        .in_dest      (mem_dest),
        .out_valid    (wb_valid),
        .out_wb_en    (wb_wb_en),
        .out_mem_read (wb_mem_read),
        .out_dest     (wb_dest)
    );

    function automatic logic produces(input logic v, input logic w,
                                      input logic [REG_ADDR_LEN-1:0] d,
                                      input logic [REG_ADDR_LEN-1:0] r);
        return v && w && (d == r) && (r != '0);
    endfunction

    logic src2_used;
    logic exe_hit1, exe_hit2, mem_hit1, mem_hit2;
    logic unused_wb;

    // Producer matches of the ID sources against the shadow slots.
    always_comb begin
        src2_used = !id_is_imm || id_is_store;
        exe_hit1  = produces(exe_valid, exe_wb_en, exe_dest, id_src1);
        exe_hit2  = produces(exe_valid, exe_wb_en, exe_dest, id_src2);
        mem_hit1  = produces(mem_valid, mem_wb_en, mem_dest, id_src1);
        mem_hit2  = produces(mem_valid, mem_wb_en, mem_dest, id_src2);
    end

`ifdef FORWARDING_EN
    // Only a load still in EXE cannot be forwarded in time.
    always_comb begin
        hazard_stall = id_valid && !flush && exe_mem_read &&
                       (exe_hit1 || (src2_used && exe_hit2));
        exe_bubble   = hazard_stall || flush || !id_valid;
    end

    assign unused_wb = ^{wb_valid, wb_wb_en, wb_mem_read, wb_dest};
`else
    logic wb_hit1, wb_hit2;

    // Without forwarding, wait until every producer of a used source retires.
    always_comb begin
        wb_hit1      = produces(wb_valid, wb_wb_en, wb_dest, id_src1);
        wb_hit2      = produces(wb_valid, wb_wb_en, wb_dest, id_src2);
        hazard_stall = id_valid && !flush &&
                       (exe_hit1 || mem_hit1 || wb_hit1 ||
                        (src2_used && (exe_hit2 || mem_hit2 || wb_hit2)));
        exe_bubble   = hazard_stall || flush || !id_valid;
    end

    assign unused_wb = wb_mem_read;
`endif

    forw_sel_e                val1_sel_d, val1_sel_q;
    forw_sel_e                val2_sel_d, val2_sel_q;
    forw_sel_e                st_val_sel_d, st_val_sel_q;
    logic [STALL_CNT_LEN-1:0] stall_count_d, stall_count_q;

    // Selects for the instruction entering EXE; bubbles carry zero selects.
    always_comb begin
        val1_sel_d   = FORW_SEL_REG;
        val2_sel_d   = FORW_SEL_REG;
        st_val_sel_d = FORW_SEL_REG;
`ifdef FORWARDING_EN
        if (!exe_bubble) begin
            val1_sel_d = pick_sel(exe_hit1, mem_hit1);
            if (!id_is_imm)  val2_sel_d   = pick_sel(exe_hit2, mem_hit2);
            if (id_is_store) st_val_sel_d = pick_sel(exe_hit2, mem_hit2);
        end
`endif
    end

    // Saturating count of stall cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard_stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + STALL_CNT_LEN'(1);
    end

    // Select and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            val1_sel_q    <= FORW_SEL_REG;
            val2_sel_q    <= FORW_SEL_REG;
            st_val_sel_q  <= FORW_SEL_REG;
            stall_count_q <= '0;
        end else begin
            val1_sel_q    <= val1_sel_d;
            val2_sel_q    <= val2_sel_d;
            st_val_sel_q  <= st_val_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign val1_sel    = val1_sel_q;
    assign val2_sel    = val2_sel_q;
    assign ST_val_sel  = st_val_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: a pipeline-level reference model
// is compared against the DUT every cycle, with directed scenarios pinned to
// literal expectations and a randomized phase. Honours FORWARDING_EN.
module tb_forwarding_unit;

    localparam int RW     = 5;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_src1, id_src2, id_dest;
    logic          id_is_imm, id_is_store, id_wb_en, id_mem_read;
    logic          flush;
    logic [1:0]    val1_sel, val2_sel, ST_val_sel;
    logic          hazard_stall;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    forwarding_unit #(.REG_ADDR_LEN(RW), .STALL_CNT_LEN(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_is_imm    (id_is_imm),
        .id_is_store  (id_is_store),
        .id_wb_en     (id_wb_en),
        .id_mem_read  (id_mem_read),
        .id_dest      (id_dest),
        .flush        (flush),
        .val1_sel     (val1_sel),
        .val2_sel     (val2_sel),
        .ST_val_sel   (ST_val_sel),
        .hazard_stall (hazard_stall),
        .stall_count  (stall_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions by stage (0=EXE, 1=MEM, 2=WB).
    typedef struct {
        bit v;
        bit w;
        bit m;
        int d;
    } slot_t;

    slot_t pipe [3];
    int    m_sel [3];
    int    m_cnt   = 0;
    bit    m_known = 1'b0;

    int s_haz;
    int s_sel [3];
    int s_cnt;

    function automatic bit prod(input slot_t s, input int r);
        return s.v && s.w && (s.d == r) && (r != 0);
    endfunction

    function automatic bit model_hazard();
        bit s2u;
        bit hit;
        s2u = !id_is_imm || id_is_store;
        hit = 1'b0;
        if (FWD)
            hit = pipe[0].m && (prod(pipe[0], int'(id_src1)) ||
                                (s2u && prod(pipe[0], int'(id_src2))));
        else
            for (int k = 0; k < 3; k++)
                hit = hit || prod(pipe[k], int'(id_src1)) ||
                      (s2u && prod(pipe[k], int'(id_src2)));
        return id_valid && !flush && hit;
    endfunction

    function automatic int pick(input int r);
        if (!FWD) return 0;
        if (prod(pipe[0], r)) return 1;
        if (prod(pipe[1], r)) return 2;
        return 0;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit h;
        bit bub;
        int ns [3];
        @(negedge clk);
        h        = model_hazard();
        s_haz    = int'(hazard_stall);
        s_sel[0] = int'(val1_sel);
        s_sel[1] = int'(val2_sel);
        s_sel[2] = int'(ST_val_sel);
        s_cnt    = int'(stall_count);
        if (m_known) begin
            if (!rst) chk("hazard_stall", s_haz, int'(h));
            chk("val1_sel", s_sel[0], m_sel[0]);
            chk("val2_sel", s_sel[1], m_sel[1]);
            chk("ST_val_sel", s_sel[2], m_sel[2]);
            chk("stall_count", s_cnt, m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                pipe[k]  = '{0, 0, 0, 0};
                m_sel[k] = 0;
            end
            m_cnt   = 0;
            m_known = 1'b1;
        end else begin
            bub = h || flush || !id_valid;
            ns  = '{0, 0, 0};
            if (!bub) begin
                ns[0] = pick(int'(id_src1));
                if (!id_is_imm)  ns[1] = pick(int'(id_src2));
                if (id_is_store) ns[2] = pick(int'(id_src2));
            end
            if (h && m_cnt < CNTMAX) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (bub) pipe[0] = '{0, 0, 0, 0};
            else     pipe[0] = '{1, id_wb_en, id_mem_read, int'(id_dest)};
            m_sel = ns;
        end
        #1;
    endtask

    task automatic set_id(input bit v, input int s1, input int s2, input bit imm,
                          input bit st, input bit wb, input bit mr, input int d);
        id_valid    = v;
        id_src1     = s1[RW-1:0];
        id_src2     = s2[RW-1:0];
        id_is_imm   = imm;
        id_is_store = st;
        id_wb_en    = wb;
        id_mem_read = mr;
        id_dest     = d[RW-1:0];
        flush       = 1'b0;
    endtask

    // Present an instruction and hold it until it leaves ID; returns stall cycles.
    task automatic issue(input int s1, input int s2, input bit imm, input bit st,
                         input bit wb, input bit mr, input int d, output int stalls);
        set_id(1'b1, s1, s2, imm, st, wb, mr, d);
        stalls = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (s_haz == 0) break;
            stalls++;
        end
    endtask

    task automatic nop();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int st;
        rst = 1'b1;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_val1_sel", s_sel[0], 0);
        chk("reset_val2_sel", s_sel[1], 0);
        chk("reset_ST_val_sel", s_sel[2], 0);
        chk("reset_stall_count", s_cnt, 0);
        chk("reset_hazard", s_haz, 0);

        // add r3 ; sub r4,r3,r5
        issue(1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3, st);
        issue(3, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4, st);
        chk("add_sub_stalls", st, FWD ? 0 : 3);
        nop();
        chk("add_sub_val1_sel", s_sel[0], FWD ? 1 : 0);
        chk("add_sub_val2_sel", s_sel[1], 0);

        // add r3 ; unrelated ; or r6,r2,r3
        do_reset();
        issue(1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3, st);
        issue(1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 5, st);
        issue(2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 6, st);
        chk("or_reg_stalls", st, FWD ? 0 : 2);
        nop();
        chk("or_reg_val2_sel", s_sel[1], FWD ? 2 : 0);

        // same with immediate val2
        do_reset();
        issue(1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3, st);
        issue(1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 5, st);
        issue(2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 6, st);
        chk("or_imm_stalls", st, 0);
        nop();
        chk("or_imm_val2_sel", s_sel[1], 0);

        // lw r7 ; sw r7
        do_reset();
        issue(1, 2, 1'b1, 1'b0, 1'b1, 1'b1, 7, st);
        issue(1, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0, st);
        chk("lw_sw_stalls", st, FWD ? 1 : 3);
        nop();
        chk("lw_sw_ST_val_sel", s_sel[2], FWD ? 2 : 0);
        chk("lw_sw_val2_sel", s_sel[1], 0);
        chk("lw_sw_stall_count", s_cnt, FWD ? 1 : 3);

        // load-use coinciding with flush, then reset
        issue(1, 2, 1'b1, 1'b0, 1'b1, 1'b1, 7, st);
        set_id(1'b1, 7, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8);
        flush = 1'b1;
        step();
        chk("flush_hazard", s_haz, 0);
        rst = 1'b1;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("flush_count_kept", s_cnt, FWD ? 1 : 3);
        rst = 1'b0;
        step();
        chk("post_rst_val1_sel", s_sel[0], 0);
        chk("post_rst_ST_val_sel", s_sel[2], 0);
        chk("post_rst_count", s_cnt, 0);
        chk("post_rst_hazard", s_haz, 0);

        // r0 never matches
        do_reset();
        issue(1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 0, st);
        issue(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, st);
        chk("r0_stalls", st, 0);
        nop();
        chk("r0_val1_sel", s_sel[0], 0);
        chk("r0_val2_sel", s_sel[1], 0);
        chk("r0_ST_val_sel", s_sel[2], 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            id_valid    = ($urandom_range(0, 6) != 0);
            id_src1     = RW'($urandom_range(0, 7));
            id_src2     = RW'($urandom_range(0, 7));
            id_dest     = RW'($urandom_range(0, 7));
            id_is_imm   = $urandom_range(0, 2) == 0;
            id_is_store = $urandom_range(0, 3) == 0;
            id_wb_en    = $urandom_range(0, 3) != 0;
            id_mem_read = $urandom_range(0, 1) == 1;
            flush       = $urandom_range(0, 9) == 0;
            step();
        end
        rst = 1'b0;
        nop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Pipeline-control block that drives the EXE stage's three forwarding selects (`val1_sel`, `val2_sel`, `ST_val_sel`) and the load-use stall for IF/ID.

- Keeps its own shadow copy of the EXE/MEM/WB destination registers, advanced in lock-step with the datapath.
- Computes forwarding for each instruction as it moves from ID to EXE, and registers the result so the selects are stable for the whole EXE cycle.
- Sits between the ID stage and the EXE stage, alongside the pipeline registers.

## Interface
Parameters:
- `REG_ADDR_LEN`, default 5: register index width.
- `STALL_CNT_LEN`, default 32: stall counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_src1`  in  REG_ADDR_LEN  first source register.
- `id_src2`  in  REG_ADDR_LEN  second source register (ALU operand or store data).
- `id_is_imm`  in  1  ALU val2 comes from the immediate.
- `id_is_store`  in  1  instruction is a store; store data is `id_src2`.
- `id_wb_en`  in  1  instruction writes a register.
- `id_mem_read`  in  1  instruction is a load.
- `id_dest`  in  REG_ADDR_LEN  destination register.
- `flush`  in  1  squash the instruction leaving ID (taken branch).
- `val1_sel`, `val2_sel`, `ST_val_sel`  out  `FORW_SEL_LEN`  registered selects: 0 = register value, 1 = `ALU_res_MEM`, 2 = `result_WB`.
- `hazard_stall`  out  1  combinational; freezes PC and IF/ID.
- `stall_count`  out  STALL_CNT_LEN  saturating count of stall cycles.

## Operation
- Three slots `EXE`, `MEM`, `WB`, each holding {valid, wb_en, mem_read, dest}.
- Each cycle, in order:
  - `WB` <= `MEM`; `MEM` <= `EXE`.
  - `EXE` <= bubble (all zero) if `hazard_stall`, `flush`, or `!id_valid`; otherwise it loads the ID fields.
- A slot *produces* register r if valid, wb_en, dest == r, and r != 0. Register 0 never matches.
- Selects are computed when an instruction loads into `EXE`:
  - For each source, if the current `EXE` slot produces it, select 1 (that slot will be in MEM).
  - Otherwise, if the current `MEM` slot produces it, select 2.
  - Otherwise select 0.
  - MEM has priority over WB, because it is the newer value.
- Per-select rules:
  - `val1_sel` is derived from `id_src1`.
  - `val2_sel` is derived from `id_src2`; it is forced to 0 when `id_is_imm`.
  - `ST_val_sel` is derived from `id_src2` only when `id_is_store`; otherwise 0.
  - On a bubble load, all selects are 0.
- `hazard_stall` (load-use) = `id_valid` & !`flush` & `EXE`.mem_read & `EXE` produces a used source.
  - `id_src1` is always a used source.
  - `id_src2` is a used source when !`id_is_imm` or `id_is_store`.
- `stall_count` increments on each cycle with `hazard_stall`=1 and saturates at all-ones.
- Simultaneous `flush` and load-use hit: `flush` wins. There is no stall, a bubble is inserted, and the counter is unchanged.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge):
  - All slots become bubbles.
  - All selects 0, `stall_count` 0.
  - `hazard_stall` 0 in the following cycle.
- Reset mid-operation discards all in-flight tracking; the first post-reset instruction sees no producers.
- Select latency: one cycle. Selects for an instruction are valid exactly during its EXE cycle.
- `hazard_stall` has zero latency (combinational from ID inputs and the `EXE` slot). It deasserts the cycle after the load moves to MEM; the stalled instruction then gets select 2 against that load.
- A load-use pair therefore always costs exactly one stall cycle.

## Configuration
- `FORWARDING_EN` defined: behaviour as above.
- `FORWARDING_EN` undefined:
  - All three selects are constant 0.
  - `hazard_stall` asserts whenever any of `EXE`, `MEM`, or `WB` produces a used source, irrespective of mem_read.
  - Flush priority and counter rules are unchanged.

## Structure
- Shared `defines.v`:
  - `FORW_SEL_LEN` (2).
  - Select encodings `FORW_SEL_REG`=0, `FORW_SEL_MEM`=1, `FORW_SEL_WB`=2.
  - Register address width.
- One sub-module `dest_slot`: a per-stage register for {valid, wb_en, mem_read, dest} with bubble-load control, instantiated three times.
- Match and select logic stays in the top module.

## Test plan
- `add r3` followed immediately by `sub r4,r3,r5` -> `val1_sel`=1 in the sub's EXE cycle; `val2_sel`=0; no stall.
- `add r3`, then an unrelated instruction, then `or r6,r2,r3` -> `val2_sel`=2; with `id_is_imm`=1 instead -> `val2_sel`=0.
- `lw r7` followed by `sw r7` (store data is r7) -> `hazard_stall`=1 for one cycle, one bubble enters EXE, then `ST_val_sel`=2; `stall_count`=1.
- Producer with dest r0 followed by a consumer of r0 -> all selects 0, no stall.
- Load-use hit with `flush`=1 in the same cycle -> `hazard_stall`=0, EXE bubble, `stall_count` unchanged; `rst` asserted the next cycle -> selects 0, `stall_count` 0.
- Build without `FORWARDING_EN`: `add r3` then `sub r4,r3,r1` -> `hazard_stall` held for 3 cycles, then selects 0.
